// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the PWM ramp controller datapath: default duty
// resolution, slot-timer width, FSM state encodings and the slot-count helper.
// ---------------------------------------------------------------------------
package pwm_pkg;

    localparam int PWM_RES_DEF = 10;
    localparam int T_LSB_W     = 12;

    localparam logic [1:0] ENC_IDLE = 2'd0;
    localparam logic [1:0] ENC_RAMP = 2'd1;
    localparam logic [1:0] ENC_HOLD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ENC_IDLE,
        ST_RAMP = ENC_RAMP,
        ST_HOLD = ENC_HOLD
    } state_t;

    // Number of slots in one PWM period for a given duty resolution.
    function automatic int slot_max(input int res);
        return (1 << res) - 1;
    endfunction

    localparam int SLOT_MAX_DEF = (1 << PWM_RES_DEF) - 1;

endpackage

// File: rtl/pwm_period_timer.sv
// ---------------------------------------------------------------------------
// pwm_period_timer
// Mirrors the pwm_generator's period counters so the controller knows where
// each period ends. clk_cnt runs 0..t_lsb, slot_cnt runs 1..2^PWM_RES-1.
// Ports:
//   i_clk         system clock
//   i_rst_n       asynchronous active-low reset
//   i_clear       restart the period (asserted with every sync pulse)
//   i_t_lsb       clocks-per-slot minus 1
//   o_period_end  last clock of the current period
// ---------------------------------------------------------------------------
module pwm_period_timer
    import pwm_pkg::*;
#(
    parameter int PWM_RES = PWM_RES_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_clear,
    input  logic [T_LSB_W-1:0] i_t_lsb,
    output logic               o_period_end
);

    localparam logic [PWM_RES-1:0] SLOT_MAX = PWM_RES'(slot_max(PWM_RES));
    localparam logic [PWM_RES-1:0] SLOT_ONE = PWM_RES'(1);

    logic [T_LSB_W-1:0] r_clk_cnt;
    logic [PWM_RES-1:0] r_slot_cnt;
    logic               w_clk_max;
    logic               w_slot_max;

    // >= keeps the counter bounded should it ever sit above a new t_lsb.
    assign w_clk_max    = (r_clk_cnt >= i_t_lsb);
    assign w_slot_max   = (r_slot_cnt == SLOT_MAX);
    assign o_period_end = w_clk_max && w_slot_max;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clk_cnt  <= '0;
            r_slot_cnt <= SLOT_ONE;
        end else if (i_clear) begin
            r_clk_cnt  <= '0;
            r_slot_cnt <= SLOT_ONE;
        end else if (w_clk_max) begin
            r_clk_cnt  <= '0;
            r_slot_cnt <= w_slot_max ? SLOT_ONE : r_slot_cnt + SLOT_ONE;
        end else begin
            r_clk_cnt  <= r_clk_cnt + T_LSB_W'(1);
        end
    end

endmodule

// File: rtl/pwm_ramp_controller.sv
// ---------------------------------------------------------------------------
// pwm_ramp_controller
// Drives one pwm_generator. Duty targets arrive over valid/ready; the applied
// duty moves toward the target by i_step once per PWM period, and every new
// value is handed over with a one-cycle sync pulse at a period boundary.
//
//   state | meaning
//   IDLE  | generator held at duty 0, no targets accepted
//   RAMP  | applied duty != target, one step per period_end
//   HOLD  | applied duty == target, no syncs issued
//
// Ports:
//   i_clk, i_rst_n            system clock, asynchronous active-low reset
//   i_enable, i_kill          run request (level), emergency off (overrides)
//   i_t_lsb_cfg               clocks-per-slot minus 1, latched on start
//   i_step                    ramp increment per period, 0 = jump to target
//   i_target_valid/_duty      offered duty target
//   o_target_ready            target taken when valid && ready
//   o_pwm_value, o_sync_signal, o_t_lsb   generator interface
//   o_busy                    high while ramping
// ---------------------------------------------------------------------------
module pwm_ramp_controller
    import pwm_pkg::*;
#(
    parameter int PWM_RES = PWM_RES_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_enable,
    input  logic               i_kill,
    input  logic [T_LSB_W-1:0] i_t_lsb_cfg,
    input  logic [PWM_RES-1:0] i_step,
    input  logic               i_target_valid,
    input  logic [PWM_RES-1:0] i_target_duty,
    output logic               o_target_ready,
    output logic [PWM_RES-1:0] o_pwm_value,
    output logic               o_sync_signal,
    output logic [T_LSB_W-1:0] o_t_lsb,
    output logic               o_busy
);

    state_t             r_state;
    logic [PWM_RES-1:0] r_target;
    logic [PWM_RES-1:0] r_pwm_value;
    logic               r_sync;
    logic               r_sync_pend;
    logic [T_LSB_W-1:0] r_t_lsb;
    logic               r_ready;
    logic               r_busy;

    logic               w_period_end;
    logic               w_stop;
    logic               w_start;
    logic               w_step_sync;
    logic               w_sync_req;
    logic               w_sync_fire;
    logic               w_accept;
    logic [PWM_RES-1:0] w_target_next;
    logic [PWM_RES:0]   w_cur_ext;
    logic [PWM_RES:0]   w_tgt_ext;
    logic [PWM_RES:0]   w_step_ext;
    logic [PWM_RES:0]   w_diff;
    logic [PWM_RES:0]   w_moved;
    logic [PWM_RES-1:0] w_ramp_next;

    pwm_period_timer #(.PWM_RES(PWM_RES)) u_timer (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_clear      (w_sync_fire),
        .i_t_lsb      (r_t_lsb),
        .o_period_end (w_period_end)
    );

    assign w_stop        = (r_state != ST_IDLE) && (i_kill || !i_enable);
    assign w_start       = (r_state == ST_IDLE) && i_enable && !i_kill;
    assign w_step_sync   = (r_state == ST_RAMP) && w_period_end && !w_stop;
    assign w_sync_req    = w_stop || w_start || w_step_sync;
    // A request landing on a cycle that already carries a sync is deferred by
    // one cycle so the pulse never stretches; the generator then latches the
    // most recent pwm_value.
    assign w_sync_fire   = (w_sync_req || r_sync_pend) && !r_sync;
    assign w_accept      = i_target_valid && r_ready && !w_stop;
    assign w_target_next = w_accept ? i_target_duty : r_target;

    // Extra bit keeps cur+step and the differences free of wrap-around.
    always_comb begin
        w_cur_ext   = {1'b0, r_pwm_value};
        w_tgt_ext   = {1'b0, r_target};
        w_step_ext  = {1'b0, i_step};
        w_diff      = '0;
        w_moved     = '0;
        w_ramp_next = r_target;
        if (w_tgt_ext >= w_cur_ext) begin
            w_diff  = w_tgt_ext - w_cur_ext;
            w_moved = w_cur_ext + w_step_ext;
        end else begin
            w_diff  = w_cur_ext - w_tgt_ext;
            w_moved = w_cur_ext - w_step_ext;
        end
        if ((i_step != '0) && (w_diff > w_step_ext)) begin
            w_ramp_next = w_moved[PWM_RES-1:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_target    <= '0;
            r_pwm_value <= '0;
            r_sync      <= 1'b0;
            r_sync_pend <= 1'b0;
            r_t_lsb     <= '0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_sync      <= w_sync_fire;
            r_sync_pend <= (w_sync_req || r_sync_pend) && r_sync;
            if (w_stop) begin
                r_state     <= ST_IDLE;
                r_pwm_value <= '0;
                r_target    <= '0;
                r_ready     <= 1'b0;
                r_busy      <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_start) begin
                            r_t_lsb     <= i_t_lsb_cfg;
                            r_pwm_value <= '0;
                            r_ready     <= 1'b1;
                            r_state     <= (r_target != '0) ? ST_RAMP : ST_HOLD;
                            r_busy      <= (r_target != '0);
                        end
                    end
                    ST_RAMP: begin
                        if (w_period_end) begin
                            r_pwm_value <= w_ramp_next;
                            // Compare with the target in force after this
                            // cycle so a same-cycle accept is not lost.
                            if (w_ramp_next == w_target_next) begin
                                r_state <= ST_HOLD;
                                r_busy  <= 1'b0;
                            end
                        end
                        if (w_accept) begin
                            r_target <= i_target_duty;
                        end
                    end
                    ST_HOLD: begin
                        if (w_accept) begin
                            r_target <= i_target_duty;
                            if (i_target_duty != r_pwm_value) begin
                                r_state <= ST_RAMP;
                                r_busy  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_target_ready = r_ready;
    assign o_pwm_value    = r_pwm_value;
    assign o_sync_signal  = r_sync;
    assign o_t_lsb        = r_t_lsb;
    assign o_busy         = r_busy;

endmodule

// File: tb/tb_pwm_ramp_controller.sv
module tb_pwm_ramp_controller;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        kill;
    logic [11:0] t_lsb_cfg;
    logic [9:0]  step;
    logic        target_valid;
    logic [9:0]  target_duty;
    logic        target_ready;
    logic [9:0]  pwm_value;
    logic        sync_signal;
    logic [11:0] t_lsb;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic prev_sync = 1'b0;

    logic [9:0] exp_q[$];

    pwm_ramp_controller #(.PWM_RES(10)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_enable       (enable),
        .i_kill         (kill),
        .i_t_lsb_cfg    (t_lsb_cfg),
        .i_step         (step),
        .i_target_valid (target_valid),
        .i_target_duty  (target_duty),
        .o_target_ready (target_ready),
        .o_pwm_value    (pwm_value),
        .o_sync_signal  (sync_signal),
        .o_t_lsb        (t_lsb),
        .o_busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // sync must never be high on two consecutive cycles
    always @(negedge clk) begin
        if (rst_n && sync_signal) begin
            checks++;
            if (prev_sync) begin
                errors++;
                $display("FAIL sync_consecutive at cyc %0d: got two-cycle sync, need single", cyc);
            end
        end
        prev_sync = rst_n && sync_signal;
    end

    // Waits (bounded) for the next sync pulse; no checking here.
    task automatic wait_sync(input int budget, output logic [9:0] val,
                             output logic bsy, output int stamp, output bit to);
        to = 1'b1;
        val = '0;
        bsy = 1'b0;
        stamp = 0;
        for (int i = 0; i < budget && to; i++) begin
            @(negedge clk);
            if (sync_signal) begin
                val = pwm_value;
                bsy = busy;
                stamp = cyc;
                to = 1'b0;
            end
        end
    endtask

    task automatic offer(input logic [9:0] d);
        int n;
        n = 0;
        while (!target_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        target_valid = 1'b1;
        target_duty  = d;
        @(negedge clk);
        target_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; kill = 1'b0; t_lsb_cfg = '0; step = '0;
        target_valid = 1'b0; target_duty = '0;
        #1;
        checks++;
        if ({sync_signal, pwm_value, t_lsb, target_ready, busy} !== 25'd0) begin
            errors++;
            $display("FAIL reset_outputs: got sync=%0b pwm=%0d tlsb=%0d rdy=%0b busy=%0b, need all 0",
                     sync_signal, pwm_value, t_lsb, target_ready, busy);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (sync_signal !== 1'b0 || target_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got sync=%0b rdy=%0b, need 0 0", sync_signal, target_ready);
        end
    endtask

    task automatic test_ramp_up();
        logic [9:0] v; logic b; int s, last; bit to; logic [9:0] e;
        t_lsb_cfg = 12'd0;
        step = 10'd25;
        enable = 1'b1;
        wait_sync(10, v, b, s, to);
        checks++;
        if (to || v !== 10'd0 || target_ready !== 1'b1 || b !== 1'b0) begin
            errors++;
            $display("FAIL start_sync: got to=%0b val=%0d rdy=%0b busy=%0b, need 0 val=0 rdy=1 busy=0",
                     to, v, target_ready, b);
        end
        last = s;
        offer(10'd100);
        exp_q.push_back(10'd25); exp_q.push_back(10'd50);
        exp_q.push_back(10'd75); exp_q.push_back(10'd100);
        for (int k = 0; k < 4; k++) begin
            wait_sync(1100, v, b, s, to);
            e = exp_q.pop_front();
            checks++;
            if (to || v !== e) begin
                errors++;
                $display("FAIL ramp_up_value[%0d]: got %0d (to=%0b), need %0d", k, v, to, e);
            end
            checks++;
            if (s - last != 1023) begin
                errors++;
                $display("FAIL ramp_up_spacing[%0d]: got %0d clks, need 1023", k, s - last);
            end
            checks++;
            if (b !== (e != 10'd100)) begin
                errors++;
                $display("FAIL ramp_up_busy[%0d]: got %0b, need %0b", k, b, (e != 10'd100));
            end
            last = s;
        end
        wait_sync(2100, v, b, s, to);
        checks++;
        if (!to) begin
            errors++;
            $display("FAIL hold_no_sync: got sync with %0d, need none", v);
        end
    endtask

    task automatic test_jump_down();
        logic [9:0] v; logic b; int s, last; bit to; logic [9:0] e;
        step = 10'd0;
        offer(10'd10);
        exp_q.push_back(10'd10);
        wait_sync(1100, v, b, s, to);
        e = exp_q.pop_front();
        checks++;
        if (to || v !== e || b !== 1'b0) begin
            errors++;
            $display("FAIL jump_down: got %0d busy=%0b (to=%0b), need %0d busy=0", v, b, to, e);
        end
        offer(10'd100);
        wait_sync(1100, v, b, s, to);
        checks++;
        if (to || v !== 10'd100) begin
            errors++;
            $display("FAIL jump_up: got %0d (to=%0b), need 100", v, to);
        end
        step = 10'd40;
        offer(10'd10);
        exp_q.push_back(10'd60); exp_q.push_back(10'd20); exp_q.push_back(10'd10);
        last = 0;
        for (int k = 0; k < 3; k++) begin
            wait_sync(1100, v, b, s, to);
            e = exp_q.pop_front();
            checks++;
            if (to || v !== e) begin
                errors++;
                $display("FAIL ramp_down_value[%0d]: got %0d (to=%0b), need %0d", k, v, to, e);
            end
            if (k > 0) begin
                checks++;
                if (s - last != 1023) begin
                    errors++;
                    $display("FAIL ramp_down_spacing[%0d]: got %0d clks, need 1023", k, s - last);
                end
            end
            last = s;
        end
    endtask

    task automatic test_retarget();
        logic [9:0] v; logic b; int s; bit to; logic [9:0] e;
        step = 10'd0;
        offer(10'd0);
        wait_sync(1100, v, b, s, to);
        checks++;
        if (to || v !== 10'd0) begin
            errors++;
            $display("FAIL retarget_base: got %0d (to=%0b), need 0", v, to);
        end
        step = 10'd100;
        offer(10'd500);
        exp_q.push_back(10'd100); exp_q.push_back(10'd200);
        for (int k = 0; k < 2; k++) begin
            wait_sync(1100, v, b, s, to);
            e = exp_q.pop_front();
            checks++;
            if (to || v !== e || b !== 1'b1) begin
                errors++;
                $display("FAIL retarget_ramp[%0d]: got %0d busy=%0b (to=%0b), need %0d busy=1",
                         k, v, b, to, e);
            end
        end
        offer(10'd150);
        exp_q.push_back(10'd150);
        wait_sync(1100, v, b, s, to);
        e = exp_q.pop_front();
        checks++;
        if (to || v !== e || b !== 1'b0) begin
            errors++;
            $display("FAIL retarget_final: got %0d busy=%0b (to=%0b), need %0d busy=0", v, b, to, e);
        end
    endtask

    task automatic test_kill_enable();
        logic [9:0] v; logic b; int s; bit to;
        step = 10'd50;
        offer(10'd600);
        wait_sync(1100, v, b, s, to);
        checks++;
        if (to || v !== 10'd200 || b !== 1'b1) begin
            errors++;
            $display("FAIL kill_pre_ramp: got %0d busy=%0b (to=%0b), need 200 busy=1", v, b, to);
        end
        repeat (5) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        checks++;
        if (sync_signal !== 1'b1 || pwm_value !== 10'd0 || target_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL kill_ramp: got sync=%0b pwm=%0d rdy=%0b busy=%0b, need 1 0 0 0",
                     sync_signal, pwm_value, target_ready, busy);
        end
        wait_sync(3000, v, b, s, to);
        checks++;
        if (!to) begin
            errors++;
            $display("FAIL kill_held: got restart sync, need none while kill=1");
        end
        kill = 1'b0;
        wait_sync(5, v, b, s, to);
        checks++;
        if (to || v !== 10'd0 || target_ready !== 1'b1) begin
            errors++;
            $display("FAIL kill_release: got to=%0b val=%0d rdy=%0b, need sync val=0 rdy=1",
                     to, v, target_ready);
        end
        repeat (5) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if (sync_signal !== 1'b1 || pwm_value !== 10'd0 || target_ready !== 1'b0) begin
            errors++;
            $display("FAIL enable_fall: got sync=%0b pwm=%0d rdy=%0b, need 1 0 0",
                     sync_signal, pwm_value, target_ready);
        end
    endtask

    task automatic test_timing();
        logic [9:0] v; logic b; int s, last; bit to; logic [9:0] e;
        repeat (3) @(negedge clk);
        t_lsb_cfg = 12'd3;
        enable = 1'b1;
        wait_sync(10, v, b, s, to);
        checks++;
        if (to || t_lsb !== 12'd3) begin
            errors++;
            $display("FAIL tlsb_latch: got %0d (to=%0b), need 3", t_lsb, to);
        end
        last = s;
        t_lsb_cfg = 12'd7;
        step = 10'd1;
        offer(10'd2);
        exp_q.push_back(10'd1); exp_q.push_back(10'd2);
        for (int k = 0; k < 2; k++) begin
            wait_sync(4200, v, b, s, to);
            e = exp_q.pop_front();
            checks++;
            if (to || v !== e || s - last != 4092) begin
                errors++;
                $display("FAIL tlsb_spacing[%0d]: got val=%0d gap=%0d (to=%0b), need val=%0d gap=4092",
                         k, v, s - last, to, e);
            end
            last = s;
        end
        checks++;
        if (t_lsb !== 12'd3) begin
            errors++;
            $display("FAIL tlsb_hold: got %0d, need 3", t_lsb);
        end
    endtask

    task automatic test_reset_mid_ramp();
        logic [9:0] v; logic b; int s; bit to;
        enable = 1'b0;
        wait_sync(5, v, b, s, to);
        repeat (3) @(negedge clk);
        t_lsb_cfg = 12'd0;
        enable = 1'b1;
        wait_sync(5, v, b, s, to);
        step = 10'd10;
        offer(10'd500);
        wait_sync(1100, v, b, s, to);
        checks++;
        if (to || v !== 10'd10 || b !== 1'b1) begin
            errors++;
            $display("FAIL mid_ramp_pre: got %0d busy=%0b (to=%0b), need 10 busy=1", v, b, to);
        end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({sync_signal, pwm_value, t_lsb, target_ready, busy} !== 25'd0) begin
            errors++;
            $display("FAIL reset_mid_ramp: got sync=%0b pwm=%0d tlsb=%0d rdy=%0b busy=%0b, need all 0",
                     sync_signal, pwm_value, t_lsb, target_ready, busy);
        end
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_sync(2100, v, b, s, to);
        checks++;
        if (!to || target_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got sync=%0b rdy=%0b, need no sync rdy=0", !to, target_ready);
        end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_jump_down();
        test_retarget();
        test_kill_enable();
        test_timing();
        test_reset_mid_ramp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
